fanout_fork_buffer: RTL and testbench

FANOUT_FORK_BUFFER -- requirements
Module: fanout_fork_buffer

---
 rtl/fanout_fork_buffer.sv | 102 ++++++++++
 tb/tb_fanout_fork_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_fork_buffer.sv
// Eager-fork fanout buffer: one in-order FIFO feeding NUM_OUT branches, each accepting the head token once.
// Optional macro FANOUT_FORK_SKID_EN selects depth 2 with registered in_ready; default is depth 1.
module fanout_fork_buffer #(
    parameter int DATA_WIDTH = 17,
    parameter int NUM_OUT    = 3,
    parameter int SEL_BIT    = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_OUT-1:0]            cfg_en,
    input  logic [NUM_OUT*32-1:0]         cfg_word,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready
);

`ifdef FANOUT_FORK_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic [DATA_WIDTH-1:0] r_mem [0:1];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic [NUM_OUT-1:0]    r_done;

    logic [NUM_OUT-1:0]    w_active;
    logic [NUM_OUT-1:0]    w_accept;
    logic                  w_nonempty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_unused_cfg;

    // Only the selector bit of each config word matters; the rest is reduced into a sink.
    assign w_unused_cfg = ^cfg_word;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_active = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_active[i] = cfg_en[i] & cfg_word[32*i + SEL_BIT];
        end
    end

    assign w_nonempty = (r_count != 2'd0);
    assign out_valid  = {NUM_OUT{w_nonempty}} & w_active & ~r_done;
    assign w_accept   = out_valid & out_ready;

    // Pop once every active branch has taken the head, now or in an earlier cycle.
    assign w_pop  = clk_en & w_nonempty & (&(~w_active | r_done | w_accept));

`ifdef FANOUT_FORK_SKID_EN
    assign in_ready = (r_count < 2'(DEPTH));
`else
    assign in_ready = (r_count < 2'(DEPTH)) | w_pop;
`endif

    assign w_push = in_valid & in_ready & clk_en;

    function automatic logic ptr_next(input logic p);
        return (DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_done  <= '0;
        end else if (clk_en) begin
            if (w_push) r_wptr <= ptr_next(r_wptr);
            if (w_pop)  r_rptr <= ptr_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop) r_done <= '0;
            else       r_done <= r_done | w_accept;
        end
    end

    // NOTE: payload storage has no reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_data;
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rptr];
        end
    end

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Directed testbench for fanout_fork_buffer; expectations follow FANOUT_FORK_SKID_EN when defined.
module tb_fanout_fork_buffer;

    localparam int DW = 17;
    localparam int NO = 3;
`ifdef FANOUT_FORK_SKID_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic              clk_en;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [NO-1:0]     cfg_en;
    logic [NO*32-1:0]  cfg_word;
    logic [NO*DW-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    fanout_fork_buffer #(.DATA_WIDTH(DW), .NUM_OUT(NO), .SEL_BIT(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_en    (cfg_en),
        .cfg_word  (cfg_word),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string tag, input logic [NO-1:0] mask, input logic [DW-1:0] exp);
        for (int b = 0; b < NO; b++) begin
            if (mask[b]) check(tag, out_data[b*DW +: DW], exp);
        end
    endtask

    int pushes;

    initial begin
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        cfg_en    = 3'b111;
        cfg_word  = {3{32'h0010_0000}};
        #3;
        check("reset_out_valid", out_valid, 3'b000);
        check("reset_in_ready", in_ready, 1'b1);
        #10 rst_n = 1'b1;
        tick();

        // Clock enable low: an offered token must not be captured.
        clk_en   = 1'b0;
        in_valid = 1'b1;
        in_data  = 17'h1FFFF;
        tick();
        clk_en   = 1'b1;
        in_valid = 1'b0;
        #1;
        check("clk_en_hold", out_valid, 3'b000);

        // Full-rate stream to three ready branches.
        out_ready = 3'b111;
        for (int k = 1; k <= 9; k++) begin
            in_valid = (k <= 8);
            in_data  = DW'(k);
            #1;
            if (k > 1) begin
                check("stream_valid", out_valid, 3'b111);
                check_data("stream_data", 3'b111, DW'(k - 1));
            end else begin
                check("stream_latency", out_valid, 3'b000);
            end
            check("stream_in_ready", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("stream_drained", out_valid, 3'b000);

        // Branch 1 stalls three cycles on token 0x0A5.
        out_ready = 3'b101;
        in_valid  = 1'b1;
        in_data   = 17'h000A5;
        tick();
        in_valid = 1'b0;
        #1;
        check("stall_valid_first", out_valid, 3'b111);
        check_data("stall_data", 3'b111, 17'h000A5);
        check("stall_in_ready", in_ready, (D == 2) ? 1'b1 : 1'b0);
        tick();
        for (int c = 0; c < 2; c++) begin
            check("stall_only_b1", out_valid, 3'b010);
            tick();
        end
        out_ready = 3'b111;
        #1;
        check("stall_b1_release", out_valid, 3'b010);
        check_data("stall_b1_data", 3'b010, 17'h000A5);
        tick();
        check("stall_popped", out_valid, 3'b000);
        check("stall_in_ready_after", in_ready, 1'b1);

        // Branch 2 deselected via its config word.
        cfg_word[2*32 + 20] = 1'b0;
        out_ready = 3'b101;
        in_valid  = 1'b1;
        in_data   = 17'h00055;
        tick();
        in_valid = 1'b0;
        #1;
        check("sel_valid", out_valid, 3'b011);
        tick();
        check("sel_b1_wait", out_valid, 3'b010);
        out_ready = 3'b110;
        tick();
        check("sel_popped", out_valid, 3'b000);
        cfg_word[2*32 + 20] = 1'b1;

        // No active branch: tokens are discarded one per cycle.
        cfg_en    = 3'b000;
        out_ready = 3'b111;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 4);
            in_data  = DW'(17'h300 + k);
            #1;
            check("discard_valid", out_valid, 3'b000);
            check("discard_in_ready", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        cfg_en   = 3'b111;
        #1;
        check("discard_empty", out_valid, 3'b000);

        // Fill with all branches stalled, then drain in order.
        out_ready = 3'b000;
        pushes    = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(17'h100 + pushes);
            #1;
            if (!in_ready) break;
            pushes++;
            tick();
        end
        check("fill_depth", pushes, D);
        in_valid  = 1'b0;
        out_ready = 3'b111;
        for (int k = 0; k < D; k++) begin
            #1;
            check("drain_valid", out_valid, 3'b111);
            check_data("drain_data", 3'b111, DW'(17'h100 + k));
            tick();
        end
        check("drain_empty", out_valid, 3'b000);

        // Asynchronous reset with a partially forked head.
        out_ready = 3'b000;
        for (int k = 0; k < D; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(17'h200 + k);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 3'b001;
        tick();
        out_ready = 3'b000;
        check("pre_reset_valid", out_valid, 3'b110);
        rst_n = 1'b0;
        #2;
        check("async_reset_valid", out_valid, 3'b000);
        check("async_reset_ready", in_ready, 1'b1);
        #1 rst_n = 1'b1;
        out_ready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_reset_empty", out_valid, 3'b000);
        end
        in_valid = 1'b1;
        in_data  = 17'h0ABCD;
        tick();
        in_valid = 1'b0;
        #1;
        check("post_reset_fresh_valid", out_valid, 3'b111);
        check_data("post_reset_fresh_data", 3'b111, 17'h0ABCD);
        tick();
        check("post_reset_final", out_valid, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
